psum_drain: RTL and testbench
=============================

# psum_drain

Read-out engine for the partial-sum memory behind the systolic core. On `start`, normally wired from the controller's `compute_done`, it reads `num_inp` consecutive psum words from the synchronous psum SRAM. It can apply per-lane ReLU, and it streams the words out on a valid/ready interface to the output path or host. This block takes over the read role currently handled in the bench by `psum_rd` and `psum_mem_dout`. It must sustain one word per cycle under continuous `out_ready` and stall cleanly under backpressure.

## Interface
- `col`, 4: lanes per psum word
- `psum_bw`, 16: bits per lane, two's complement
- `num_inp`, 8: words per drain, ≥1
- `addr_bw`, 11: psum SRAM address width (2048 words)

- `clk`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high
- `start`  in  1  drain request, sampled at rising edge; ignored unless idle
- `base_addr`  in  addr_bw  first SRAM address, sampled with `start`
- `relu`  in  1  ReLU enable, sampled with `start`, held for whole drain
- `psum_mem_cen`  out  1  SRAM chip enable, active-low; read issued when 0
- `psum_mem_addr`  out  addr_bw  SRAM read address
- `psum_mem_dout`  in  col*psum_bw  SRAM read data, valid one cycle after read issue
- `out_data`  out  col*psum_bw  output word, lane i at bits [(i+1)*psum_bw-1 : i*psum_bw]
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts; beat occurs when `out_valid && out_ready`
- `busy`  out  1  high from the cycle after `start` accept until `done`
- `done`  out  1  one-cycle pulse after final beat

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE → RUN on `start`. Latch `base_addr` and `relu`. Clear the issue counter and the beat counter.
- RUN: issue reads at `base_addr + n` for n = 0..num_inp-1. Address wraps modulo 2^addr_bw.
- Output buffer: 2-entry FIFO.
- Issue rule: a read may be issued only if buffer occupancy + reads in flight (0 or 1) < 2 and issue count < `num_inp`.
- When no read is issued, `psum_mem_cen`=1 and `psum_mem_addr` holds its last value.
- Returning data passes through ReLU when `relu`=1 and is then written into the buffer. ReLU rule: a lane with MSB=1 becomes 0; otherwise the lane passes unchanged. No saturation and no width change.
- `out_valid` = buffer not empty. `out_data` = buffer head.
- RUN → FIN in the cycle the beat counter reaches `num_inp`.
- FIN: `done`=1 for one cycle, then → IDLE.
- `start` in RUN or FIN is ignored and not queued.
- Reset wins over every other input, including a simultaneous `start`. Reset mid-drain aborts the drain and discards buffer contents and in-flight data. No `done` is produced for the aborted drain.

## Timing
- Reset values: `psum_mem_cen`=1, `psum_mem_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. State is IDLE.
- Let E0 be the edge at which `start` is accepted.
- Cycle after E0: `busy`=1, `psum_mem_cen`=0, `psum_mem_addr`=`base_addr`.
- `out_valid` first rises in the second cycle after E0.
- With `out_ready` held high, beats occur on consecutive cycles. The last beat occurs `num_inp`+1 cycles after E0.
- `done` pulses in the cycle following the last beat. `busy` falls in the same cycle as the `done` pulse.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_valid` stay stable. After the buffer fills, at most 0 further reads are issued.
- Back-to-back: a new `start` is accepted in the cycle after `done`. The minimum gap between drains is 2 idle cycles.
- Data order equals address order. No word is lost or duplicated under any `out_ready` pattern.

## Test plan
- **Basic drain:** preload SRAM[0..7] with word k = lanes {k, k+1, k+2, k+3}; `base_addr`=0, `relu`=0, `out_ready`=1; pulse `start` → 8 consecutive beats in address order. `done` is high exactly 1 cycle after beat 8. `cen`=0 for exactly 8 cycles.
- **ReLU:** SRAM[0] lanes {16'hFFF6 (-10), 5, 16'h8000, 0}; `relu`=1 → beat 0 = {0, 5, 0, 0}. Repeat with `relu`=0 → {FFF6, 0005, 8000, 0000} unchanged.
- **Backpressure:** `out_ready` pattern 1,0,0,1,0,1,1,... (pseudo-random, 50%) → 8 beats with correct values. `out_data` is stable while stalled. Buffer never overflows: a monitor checks outstanding ≤2.
- **Wrap:** `base_addr`=2045, `num_inp`=8 → addresses 2045, 2046, 2047, 0, 1, 2, 3, 4 in order.
- **Mid-drain reset and start handling:** assert `reset` after beat 3 → all outputs return to reset values on the next cycle and no `done` is produced. Then `start` → full 8-beat drain from word 0. Additionally, pulse `start` during RUN → ignored; exactly 8 beats and one `done`.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: reads num_inp consecutive words from the synchronous psum SRAM, applies optional
// per-lane ReLU and streams them out through a 2-entry buffer on a valid/ready interface.
module psum_drain #(
   parameter int unsigned col     = 4,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned num_inp = 8,
   parameter int unsigned addr_bw = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [addr_bw-1:0]     base_addr,
   input  logic                   relu,
   output logic                   psum_mem_cen,
   output logic [addr_bw-1:0]     psum_mem_addr,
   input  logic [col*psum_bw-1:0] psum_mem_dout,
   output logic [col*psum_bw-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned CntW  = $clog2(num_inp + 1);
   localparam int unsigned WordW = col * psum_bw;

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e state_q, state_d;

   logic [addr_bw-1:0] base_q, addr_q;
   logic               relu_q;
   logic [CntW-1:0]    issue_cnt_q, beat_cnt_q;
   logic               inflight_q;
   logic [WordW-1:0]   buf_q [2];
   logic               wr_ptr_q, rd_ptr_q;
   logic [1:0]         count_q;

   logic             accept, issue, beat, push, pop, last_beat;
   logic [WordW-1:0] in_word;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_beat) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy   = (state_q == StRun);
      done   = (state_q == StFin);
      accept = (state_q == StIdle) && start;
   end

   always_comb begin
      in_word = psum_mem_dout;
      if (relu_q) begin
         for (int i = 0; i < int'(col); i++) begin
            if (psum_mem_dout[i*psum_bw + psum_bw - 1]) in_word[i*psum_bw +: psum_bw] = '0;
         end
      end
   end

   // An empty buffer forwards returning SRAM data directly so the first word appears
   // one cycle after its read and a full-rate stream never stores anything.
   always_comb begin
      out_valid     = (count_q != 2'd0) || inflight_q;
      out_data      = (count_q == 2'd0 && inflight_q) ? in_word : buf_q[rd_ptr_q];
      beat          = out_valid && out_ready;
      pop           = beat && (count_q != 2'd0);
      push          = inflight_q && !(beat && count_q == 2'd0);
      issue         = (state_q == StRun) && (issue_cnt_q < CntW'(num_inp)) &&
                      ((3'(count_q) + 3'(inflight_q)) < 3'd2);
      psum_mem_cen  = !issue;
      psum_mem_addr = issue ? base_q + addr_bw'(issue_cnt_q) : addr_q;
      last_beat     = beat && (beat_cnt_q == CntW'(num_inp - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q      <= '0;
         addr_q      <= '0;
         relu_q      <= 1'b0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         inflight_q  <= 1'b0;
         buf_q[0]    <= '0;
         buf_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         if (accept) begin
            base_q      <= base_addr;
            relu_q      <= relu;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
         end else begin
            if (issue) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (beat) beat_cnt_q <= beat_cnt_q + 1'b1;
         end
         inflight_q <= issue;
         addr_q     <= psum_mem_addr;
         if (push) begin
            buf_q[wr_ptr_q] <= in_word;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: random SRAM contents and out_ready patterns are checked
// against a reference model that derives each expected word directly from memory contents.
`timescale 1ns/1ps
module tb_psum_drain;

   localparam int NumInp = 8;

   logic        clk = 1'b0;
   logic        reset, start, relu, out_ready;
   logic [10:0] base_addr;
   logic        psum_mem_cen;
   logic [10:0] psum_mem_addr;
   logic [63:0] psum_mem_dout = '0;
   logic [63:0] out_data;
   logic        out_valid, busy, done;

   logic [63:0] mem [2048];

   int checks = 0;
   int errors = 0;

   // Observations of the most recent drain
   logic [63:0] got_q[$];
   logic [10:0] addr_seen[$];
   int          beats, issued, cen_low, first_valid, last_beat, done_cyc, dones;
   int          busy_fall, late_busy, max_out, stall_bad, abort_cyc;
   logic        busy1, cen1, rst_ok;
   logic [10:0] addr1;

   psum_drain dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .relu         (relu),
      .psum_mem_cen (psum_mem_cen),
      .psum_mem_addr(psum_mem_addr),
      .psum_mem_dout(psum_mem_dout),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!psum_mem_cen) psum_mem_dout <= mem[psum_mem_addr];
   end

   // Expected k-th word of a drain: memory word at (base+k) mod 2048, negative lanes zeroed.
   function automatic logic [63:0] model_word(input logic [10:0] base, input int k,
                                              input logic rl);
      logic [63:0] w;
      w = mem[(int'(base) + k) % 2048];
      if (rl) begin
         for (int i = 0; i < 4; i++) begin
            if ($signed(w[i*16 +: 16]) < 0) w[i*16 +: 16] = 16'h0000;
         end
      end
      return w;
   endfunction

   task automatic fill_random();
      for (int a = 0; a < 2048; a++) mem[a] = {$urandom, $urandom};
   endtask

   task automatic run_drain(input logic [10:0] base, input logic rl, input bit rand_ready,
                            input int mid_start, input int abort_after, input bit tight);
      bit          prev_stall;
      logic [63:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      got_q.delete();
      addr_seen.delete();
      beats = 0; issued = 0; cen_low = 0; first_valid = 0; last_beat = 0; done_cyc = 0;
      dones = 0; busy_fall = 0; late_busy = 0; max_out = 0; stall_bad = 0; abort_cyc = 0;
      rst_ok = 1'b0; busy1 = 1'b0; cen1 = 1'b1; addr1 = '0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; relu = rl; out_ready = 1'b1; reset = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(posedge clk); #1;
         start     = (cyc == mid_start);
         base_addr = 11'($urandom);
         relu      = 1'($urandom);
         out_ready = rand_ready ? 1'($urandom) : 1'b1;
         reset     = (abort_cyc != 0 && cyc == abort_cyc);
         if (reset) out_ready = 1'b0;
         #1;
         if (abort_cyc != 0 && cyc == abort_cyc + 1)
            rst_ok = psum_mem_cen === 1'b1 && psum_mem_addr === 11'd0 && out_data === 64'd0 &&
                     out_valid === 1'b0 && busy === 1'b0 && done === 1'b0;
         if (cyc == 1) begin
            busy1 = busy; cen1 = psum_mem_cen; addr1 = psum_mem_addr;
         end
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (psum_mem_cen === 1'b0) begin
               cen_low++; issued++; addr_seen.push_back(psum_mem_addr);
            end
            if (out_valid === 1'b1 && first_valid == 0) first_valid = cyc;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_bad++;
            if (out_valid === 1'b1 && out_ready) begin
               got_q.push_back(out_data); beats++; last_beat = cyc;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            if (done === 1'b1) begin
               dones++;
               if (done_cyc == 0) done_cyc = cyc;
            end
            if (busy === 1'b1 && done_cyc != 0) late_busy++;
            if (cyc > 1 && busy === 1'b0 && busy_fall == 0) busy_fall = cyc;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
         end
         if (abort_after > 0 && abort_cyc == 0 && beats == abort_after) abort_cyc = cyc + 1;
         if (abort_cyc != 0 && cyc >= abort_cyc + 12) break;
         if (abort_cyc == 0 && done_cyc != 0 && cyc >= done_cyc + (tight ? 0 : 2)) break;
      end
      start = 1'b0; reset = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; base_addr = 11'h155; relu = 1'b1; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0; start = 1'b0;
      #1;
      checks++; if (psum_mem_cen !== 1'b1) begin errors++; $display("FAIL reset_cen got %b want 1", psum_mem_cen); end
      checks++; if (psum_mem_addr !== 11'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", psum_mem_addr); end
      checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      @(posedge clk); #2;
      checks++; if (busy !== 1'b0 || psum_mem_cen !== 1'b1) begin errors++; $display("FAIL reset_start_wins busy %b cen %b want 0 1", busy, psum_mem_cen); end
   endtask

   task automatic test_basic();
      for (int k = 0; k < NumInp; k++)
         mem[k] = {16'(k + 3), 16'(k + 2), 16'(k + 1), 16'(k)};
      run_drain(11'd0, 1'b0, 1'b0, 0, 0, 1'b0);
      checks++; if (got_q.size() != NumInp) begin errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), NumInp); end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== model_word(11'd0, k, 1'b0)) begin errors++; $display("FAIL basic_word%0d got %h want %h", k, got_q[k], model_word(11'd0, k, 1'b0)); end
      end
      checks++; if (busy1 !== 1'b1 || cen1 !== 1'b0 || addr1 !== 11'd0) begin errors++; $display("FAIL basic_first_cycle busy %b cen %b addr %0d want 1 0 0", busy1, cen1, addr1); end
      checks++; if (first_valid != 2) begin errors++; $display("FAIL basic_first_valid got %0d want 2", first_valid); end
      checks++; if (last_beat != NumInp + 1) begin errors++; $display("FAIL basic_last_beat got %0d want %0d", last_beat, NumInp + 1); end
      checks++; if (done_cyc != NumInp + 2 || dones != 1) begin errors++; $display("FAIL basic_done cycle %0d count %0d want %0d 1", done_cyc, dones, NumInp + 2); end
      checks++; if (busy_fall != NumInp + 2) begin errors++; $display("FAIL basic_busy_fall got %0d want %0d", busy_fall, NumInp + 2); end
      checks++; if (cen_low != NumInp) begin errors++; $display("FAIL basic_cen_low got %0d want %0d", cen_low, NumInp); end
   endtask

   task automatic test_relu();
      logic [63:0] w0;
      w0 = {16'h0000, 16'h8000, 16'h0005, 16'hFFF6};
      mem[0] = w0;
      for (int k = 1; k < NumInp; k++) mem[k] = {$urandom, $urandom};
      run_drain(11'd0, 1'b1, 1'b0, 0, 0, 1'b0);
      checks++; if (got_q.size() != NumInp) begin errors++; $display("FAIL relu_count got %0d want %0d", got_q.size(), NumInp); end
      if (got_q.size() > 0) begin
         checks++; if (got_q[0] !== 64'h0000_0000_0005_0000) begin errors++; $display("FAIL relu_on_word0 got %h want 0000000000050000", got_q[0]); end
      end
      for (int k = 1; k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== model_word(11'd0, k, 1'b1)) begin errors++; $display("FAIL relu_on_word%0d got %h want %h", k, got_q[k], model_word(11'd0, k, 1'b1)); end
      end
      run_drain(11'd0, 1'b0, 1'b0, 0, 0, 1'b0);
      checks++; if (got_q.size() != NumInp) begin errors++; $display("FAIL relu_off_count got %0d want %0d", got_q.size(), NumInp); end
      if (got_q.size() > 0) begin
         checks++; if (got_q[0] !== w0) begin errors++; $display("FAIL relu_off_word0 got %h want %h", got_q[0], w0); end
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] b;
      logic        rl;
      fill_random();
      for (int rep = 0; rep < 4; rep++) begin
         b  = 11'($urandom);
         rl = 1'($urandom);
         run_drain(b, rl, 1'b1, 0, 0, 1'b0);
         checks++; if (got_q.size() != NumInp) begin errors++; $display("FAIL bp_count rep%0d got %0d want %0d", rep, got_q.size(), NumInp); end
         for (int k = 0; k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== model_word(b, k, rl)) begin errors++; $display("FAIL bp_word rep%0d k%0d got %h want %h", rep, k, got_q[k], model_word(b, k, rl)); end
         end
         checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable rep%0d unstable stalls %0d want 0", rep, stall_bad); end
         checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding rep%0d got %0d want <=2", rep, max_out); end
         checks++; if (dones != 1 || done_cyc != last_beat + 1) begin errors++; $display("FAIL bp_done rep%0d count %0d cycle %0d want 1 %0d", rep, dones, done_cyc, last_beat + 1); end
         checks++; if (cen_low != NumInp) begin errors++; $display("FAIL bp_reads rep%0d got %0d want %0d", rep, cen_low, NumInp); end
      end
   endtask

   task automatic test_wrap();
      fill_random();
      run_drain(11'd2045, 1'b0, 1'b1, 0, 0, 1'b0);
      checks++; if (addr_seen.size() != NumInp) begin errors++; $display("FAIL wrap_reads got %0d want %0d", addr_seen.size(), NumInp); end
      for (int k = 0; k < addr_seen.size(); k++) begin
         checks++; if (int'(addr_seen[k]) != (2045 + k) % 2048) begin errors++; $display("FAIL wrap_addr%0d got %0d want %0d", k, addr_seen[k], (2045 + k) % 2048); end
      end
      checks++; if (got_q.size() != NumInp) begin errors++; $display("FAIL wrap_count got %0d want %0d", got_q.size(), NumInp); end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== model_word(11'd2045, k, 1'b0)) begin errors++; $display("FAIL wrap_word%0d got %h want %h", k, got_q[k], model_word(11'd2045, k, 1'b0)); end
      end
   endtask

   task automatic test_mid_reset();
      fill_random();
      run_drain(11'd0, 1'b0, 1'b0, 0, 3, 1'b0);
      checks++; if (rst_ok !== 1'b1) begin errors++; $display("FAIL midrst_outputs got %b want 1", rst_ok); end
      checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      checks++; if (beats != 3) begin errors++; $display("FAIL midrst_beats got %0d want 3", beats); end
      run_drain(11'd0, 1'b0, 1'b1, 0, 0, 1'b0);
      checks++; if (got_q.size() != NumInp || dones != 1) begin errors++; $display("FAIL midrst_redrain count %0d dones %0d want %0d 1", got_q.size(), dones, NumInp); end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== model_word(11'd0, k, 1'b0)) begin errors++; $display("FAIL midrst_word%0d got %h want %h", k, got_q[k], model_word(11'd0, k, 1'b0)); end
      end
   endtask

   task automatic test_start_ignored();
      logic [10:0] b;
      b = 11'($urandom);
      run_drain(b, 1'b0, 1'b1, 4, 0, 1'b0);
      checks++; if (got_q.size() != NumInp || dones != 1 || cen_low != NumInp) begin errors++; $display("FAIL ign_run count %0d dones %0d reads %0d want %0d 1 %0d", got_q.size(), dones, cen_low, NumInp, NumInp); end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== model_word(b, k, 1'b0)) begin errors++; $display("FAIL ign_run_word%0d got %h want %h", k, got_q[k], model_word(b, k, 1'b0)); end
      end
      run_drain(b, 1'b1, 1'b0, NumInp + 2, 0, 1'b0);
      checks++; if (late_busy != 0 || cen_low != NumInp || dones != 1) begin errors++; $display("FAIL ign_fin late_busy %0d reads %0d dones %0d want 0 %0d 1", late_busy, cen_low, dones, NumInp); end
   endtask

   task automatic test_back_to_back();
      logic [10:0] b1, b2;
      b1 = 11'($urandom);
      b2 = 11'($urandom);
      run_drain(b1, 1'b1, 1'b0, 0, 0, 1'b1);
      checks++; if (got_q.size() != NumInp || dones != 1) begin errors++; $display("FAIL b2b_first count %0d dones %0d want %0d 1", got_q.size(), dones, NumInp); end
      run_drain(b2, 1'b0, 1'b0, 0, 0, 1'b0);
      checks++; if (busy1 !== 1'b1 || cen1 !== 1'b0 || addr1 !== b2) begin errors++; $display("FAIL b2b_accept busy %b cen %b addr %0d want 1 0 %0d", busy1, cen1, addr1, b2); end
      checks++; if (first_valid != 2 || dones != 1) begin errors++; $display("FAIL b2b_timing first_valid %0d dones %0d want 2 1", first_valid, dones); end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== model_word(b2, k, 1'b0)) begin errors++; $display("FAIL b2b_word%0d got %h want %h", k, got_q[k], model_word(b2, k, 1'b0)); end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; relu = 1'b0; out_ready = 1'b1; base_addr = '0;
      for (int a = 0; a < 2048; a++) mem[a] = '0;
      test_reset();
      test_basic();
      test_relu();
      test_backpressure();
      test_wrap();
      test_mid_reset();
      test_start_ignored();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
